// File: rtl/ufp_pkg.sv
// rtl/ufp_pkg.sv - shared constants, state encoding and helpers for the peak normaliser
package ufp_pkg;

  localparam int UFP_W = 9;
  localparam logic [UFP_W-1:0] UFP_ONE   = 9'h100;
  localparam logic [UFP_W-1:0] UFP_FLOOR = 9'h020;

  typedef enum logic {
    FILL   = 1'b0,
    DIVIDE = 1'b1
  } ufp_state_e;

  function automatic logic [UFP_W-1:0] ufp_max(input logic [UFP_W-1:0] a,
                                               input logic [UFP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ufp_sample_buf.sv
// rtl/ufp_sample_buf.sv - DEPTH x UFP_W register file, synchronous write, combinational read
module ufp_sample_buf
  import ufp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [UFP_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [UFP_W-1:0] rdata
);

  logic [UFP_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ufp_peak_norm.sv
// rtl/ufp_peak_norm.sv - block peak normaliser feeding an external 1.8 divider
// Optional gain limit selected with UFP_NORM_FLOOR_EN.
module ufp_peak_norm
  import ufp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = UFP_W
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iValid,
  input  logic [W-1:0] iSample,
  output logic         oReady,
  output logic [W-1:0] oQ,
  output logic [W-1:0] oD,
  input  logic [W-1:0] iR,
  output logic         oValid,
  output logic [W-1:0] oNorm,
  input  logic         iReady,
  output logic         oBusy
);

  localparam int AW = $clog2(DEPTH);

  ufp_state_e   state, state_nxt;
  logic [AW-1:0] wr_cnt;
  logic [AW:0]   rd_idx;
  logic [W-1:0]  peak;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  divisor;
  logic [W-1:0]  norm_val;
  logic          accept, fill_last, slot_free, issue, done;

  assign accept    = (state == FILL) && iValid;
  assign fill_last = accept && (wr_cnt == AW'(DEPTH - 1));
  assign slot_free = !oValid || iReady;
  assign issue     = (state == DIVIDE) && slot_free && (rd_idx < (AW+1)'(DEPTH));
  assign done      = (state == DIVIDE) && oValid && iReady && (rd_idx == (AW+1)'(DEPTH));

  ufp_sample_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (iCLK),
    .we    (accept),
    .waddr (wr_cnt),
    .wdata (iSample),
    .raddr (rd_idx[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef UFP_NORM_FLOOR_EN
  // A floored divisor caps gain at 8x and makes an all-zero block divide to zero.
  assign divisor  = ufp_max(peak, UFP_FLOOR);
  assign norm_val = iR;
`else
  assign divisor  = (peak == '0) ? UFP_ONE : peak;
  assign norm_val = (peak == '0) ? '0 : iR;
`endif

  always_comb begin
    state_nxt = state;
    oReady    = 1'b0;
    oBusy     = 1'b0;
    oQ        = '0;
    oD        = UFP_ONE;
    case (state)
      FILL: begin
        oReady = 1'b1;
        if (fill_last) state_nxt = DIVIDE;
      end
      DIVIDE: begin
        oBusy = 1'b1;
        oQ    = rd_data;
        oD    = divisor;
        if (done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= FILL;
    else      state <= state_nxt;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_cnt <= '0;
      rd_idx <= '0;
      peak   <= '0;
      oValid <= 1'b0;
      oNorm  <= '0;
    end else if (state == FILL) begin
      rd_idx <= '0;
      if (iValid) begin
        peak   <= ufp_max(peak, iSample);
        wr_cnt <= wr_cnt + 1'b1;
      end
    end else if (done) begin
      oValid <= 1'b0;
      peak   <= '0;
      wr_cnt <= '0;
      rd_idx <= '0;
    end else if (issue) begin
      oNorm  <= norm_val;
      oValid <= 1'b1;
      rd_idx <= rd_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_ufp_peak_norm.sv
// tb/tb_ufp_peak_norm.sv - table-driven scoreboard bench for ufp_peak_norm (DEPTH=4)
module tb_ufp_peak_norm;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0][8:0] smp;
    logic [3:0][8:0] exp;
    logic [8:0]      d;
  } vec_t;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iValid = 1'b0;
  logic [8:0] iSample = '0;
  logic       oReady;
  logic [8:0] oQ, oD, iR;
  logic       oValid;
  logic [8:0] oNorm;
  logic       iReady = 1'b1;
  logic       oBusy;

  logic [16:0] num, quo;
  vec_t        vecs[5];
  logic [8:0]  q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 iCLK = ~iCLK;

  // External divider model: (oQ << 8) / oD, truncated.
  always_comb begin
    num = {oQ, 8'h00};
    quo = (oD == '0) ? '0 : num / {8'h00, oD};
    iR  = quo[8:0];
  end

  ufp_peak_norm #(.DEPTH(DEPTH)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iSample(iSample),
    .oReady(oReady), .oQ(oQ), .oD(oD), .iR(iR),
    .oValid(oValid), .oNorm(oNorm), .iReady(iReady), .oBusy(oBusy)
  );

  function automatic logic [3:0][8:0] mk(input logic [8:0] a, input logic [8:0] b,
                                         input logic [8:0] c, input logic [8:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock: scoreboard at the falling edge, then step to just after the rising edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge iCLK);
    if (oValid && iReady) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got oNorm=%h, required no output", oNorm);
      end else begin
        e = q.pop_front();
        check("out_norm", {7'b0, oNorm}, {7'b0, e});
      end
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic fill(input logic [3:0][8:0] s);
    int w = 0;
    while (!oReady && w < 50) begin
      tick();
      w++;
    end
    if (!oReady) check("ready_wait", {15'b0, oReady}, 16'd1);
    for (int i = 0; i < DEPTH; i++) begin
      iValid  = 1'b1;
      iSample = s[i];
      tick();
    end
    iValid  = 1'b0;
    iSample = '0;
  endtask

  task automatic drain(output int cyc);
    cyc = 0;
    while (oBusy && cyc < 100) begin
      tick();
      cyc++;
    end
    if (oBusy) check("drain_timeout", {15'b0, oBusy}, 16'd0);
  endtask

  task automatic run_vec(input int k);
    int cyc;
    for (int i = 0; i < DEPTH; i++) q.push_back(vecs[k].exp[i]);
    fill(vecs[k].smp);
    check("busy_entry",  {15'b0, oBusy},  16'd1);
    check("ready_low",   {15'b0, oReady}, 16'd0);
    check("valid_entry", {15'b0, oValid}, 16'd0);
    check("div_d",       {7'b0, oD}, {7'b0, vecs[k].d});
    check("div_q0",      {7'b0, oQ}, {7'b0, vecs[k].smp[0]});
    iValid  = 1'b1;
    iSample = 9'h1FF;
    tick();
    check("first_valid", {15'b0, oValid}, 16'd1);
    drain(cyc);
    iValid  = 1'b0;
    iSample = '0;
    check("busy_cycles", 16'(cyc + 1), 16'(DEPTH + 1));
    check("sb_empty",    16'(q.size()), 16'd0);
    check("ready_back",  {15'b0, oReady}, 16'd1);
    check("valid_back",  {15'b0, oValid}, 16'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{mk(9'h040, 9'h080, 9'h0C0, 9'h100), mk(9'h040, 9'h080, 9'h0C0, 9'h100), 9'h100};
    vecs[1] = '{mk(9'h020, 9'h040, 9'h010, 9'h080), mk(9'h040, 9'h080, 9'h020, 9'h100), 9'h080};
`ifdef UFP_NORM_FLOOR_EN
    vecs[2] = '{mk(9'h000, 9'h000, 9'h000, 9'h000), mk(9'h000, 9'h000, 9'h000, 9'h000), 9'h020};
    vecs[3] = '{mk(9'h008, 9'h004, 9'h002, 9'h001), mk(9'h040, 9'h020, 9'h010, 9'h008), 9'h020};
`else
    vecs[2] = '{mk(9'h000, 9'h000, 9'h000, 9'h000), mk(9'h000, 9'h000, 9'h000, 9'h000), 9'h100};
    vecs[3] = '{mk(9'h008, 9'h004, 9'h002, 9'h001), mk(9'h100, 9'h080, 9'h040, 9'h020), 9'h008};
`endif
    vecs[4] = '{mk(9'h010, 9'h020, 9'h040, 9'h080), mk(9'h020, 9'h040, 9'h080, 9'h100), 9'h080};

    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    tick();
    check("rst_ready", {15'b0, oReady}, 16'd1);
    check("rst_valid", {15'b0, oValid}, 16'd0);
    check("rst_busy",  {15'b0, oBusy},  16'd0);
    check("rst_norm",  {7'b0, oNorm}, 16'h000);
    check("rst_q",     {7'b0, oQ},    16'h000);
    check("rst_d",     {7'b0, oD},    16'h100);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Backpressure: hold the second output for three cycles.
    for (int i = 0; i < DEPTH; i++) q.push_back(vecs[1].exp[i]);
    fill(vecs[1].smp);
    tick();
    check("bp_first", {7'b0, oNorm}, 16'h040);
    tick();
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", {15'b0, oValid}, 16'd1);
      check("bp_hold_norm",  {7'b0, oNorm}, 16'h080);
    end
    iReady = 1'b1;
    drain(cyc);
    check("bp_sb_empty", 16'(q.size()), 16'd0);

    // Reset after two fill beats discards them.
    iValid  = 1'b1;
    iSample = 9'h0F0;
    tick();
    tick();
    iValid = 1'b0;
    iRST   = 1'b1;
    tick();
    iRST = 1'b0;
    check("rstfill_ready", {15'b0, oReady}, 16'd1);
    check("rstfill_valid", {15'b0, oValid}, 16'd0);
    run_vec(4);

    // Reset in the middle of DIVIDE drops pending output.
    for (int i = 0; i < DEPTH; i++) q.push_back(vecs[0].exp[i]);
    fill(vecs[0].smp);
    tick();
    tick();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    q.delete();
    check("rstdiv_valid", {15'b0, oValid}, 16'd0);
    check("rstdiv_busy",  {15'b0, oBusy},  16'd0);
    check("rstdiv_norm",  {7'b0, oNorm}, 16'h000);
    check("rstdiv_d",     {7'b0, oD},    16'h100);
    check("rstdiv_q",     {7'b0, oQ},    16'h000);
    run_vec(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
